// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: recovers bytes from an asynchronous idle-high serial line
// and presents each good byte with a one-cycle strobe, or flags a bad stop bit.
module uart_byte_rx #(
    parameter int unsigned CLK_HZ = 48_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          rx_sync1_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_fall;
    logic          half_hit;
    logic          full_hit;

    // A falling edge needs rx_s to have been high the cycle before, so a
    // line stuck low after a frame error cannot restart reception.
    assign rx_fall  = rx_prev_q & ~rx_s_q;
    assign half_hit = (baud_cnt_q == HALF_LAST);
    assign full_hit = (baud_cnt_q == FULL_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rx_sync1_q  <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_sync1_q  <= i_rx;
            rx_s_q      <= rx_sync1_q;
            rx_prev_q   <= rx_s_q;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_fall) state_d = START;
            START:   if (half_hit) state_d = rx_s_q ? IDLE : DATA;
            DATA:    if (full_hit && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:    if (full_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_cnt_d  = baud_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
            end
            START: begin
                if (half_hit) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                end
            end
            DATA: begin
                if (full_hit) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    baud_cnt_d         = '0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (full_hit) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: baud_cnt_d = '0;
        endcase
    end

    always_comb begin
        o_data      = data_q;
        o_valid     = valid_q;
        o_frame_err = frame_err_q;
        o_busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx at 16 clocks per bit: the stimulus pushes
// expected strobes, a negedge monitor pops and checks them as they appear.
module tb_uart_byte_rx;

    localparam int unsigned CPB     = 16;
    localparam int unsigned LATENCY = 2 + 1 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned start;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned total;
    int unsigned bad;
    int unsigned cyc;

    uart_byte_rx #(
        .CLK_HZ (1_600_000),
        .BAUD   (100_000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid === 1'b1 && frame_err === 1'b1)
            chk("valid_and_ferr_exclusive", 1, 0);
        if (valid === 1'b1 || frame_err === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, valid, frame_err}, 0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb_q.pop_front();
                lat = int'(cyc) - int'(e.start);
                chk("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                if (!e.is_err) chk("strobe_data", {24'd0, data}, {24'd0, e.data});
                chk("strobe_latency", (lat >= int'(LATENCY) - 1 && lat <= int'(LATENCY) + 1) ? 1 : lat, 1);
                chk("busy_low_at_strobe", {31'd0, busy}, 0);
            end
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is positioned 1 time unit after a posedge; leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it);
        exp_t e;
        e.is_err = ~stop;
        e.data   = b;
        e.start  = cyc;
        if (expect_it) sb_q.push_back(e);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, sb_q.size(), 0);
        wait_cycles(4);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rx    = 1'b1;
        rst_n = 1'b0;

        // 1: reset state
        wait_cycles(4);
        chk("reset_data", {24'd0, data}, 0);
        chk("reset_valid", {31'd0, valid}, 0);
        chk("reset_ferr", {31'd0, frame_err}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        wait_cycles(5);

        // 2: single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        drain("drain_a5");
        chk("hold_a5", {24'd0, data}, 32'hA5);
        chk("idle_busy_a5", {31'd0, busy}, 0);

        // 3: back-to-back with zero idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drain("drain_b2b");
        chk("hold_ff", {24'd0, data}, 32'hFF);

        // 4: stop bit low
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b1;
        drain("drain_ferr");
        chk("hold_after_ferr", {24'd0, data}, 32'hFF);

        // 5: short glitch on idle line
        rx = 1'b0;
        wait_cycles(4);
        chk("glitch_busy", {31'd0, busy}, 1);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        chk("glitch_idle", {31'd0, busy}, 0);
        chk("glitch_data", {24'd0, data}, 32'hFF);
        chk("glitch_no_strobe", sb_q.size(), 0);

        // Break: line held low for many bit times gives one frame error only
        send_frame(8'h00, 1'b0, 1'b1);
        wait_cycles(20 * CPB);
        chk("break_idle", {31'd0, busy}, 0);
        rx = 1'b1;
        drain("drain_break");
        chk("break_data", {24'd0, data}, 32'hFF);

        // 6: reset mid data bit 3 of 0x5A, then a clean 0x81
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h5A >> i) & 1'b1;
            wait_cycles(CPB);
        end
        rx = 1'b1;
        wait_cycles(CPB / 2);
        chk("mid_frame_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        wait_cycles(3);
        chk("mid_reset_busy", {31'd0, busy}, 0);
        chk("mid_reset_data", {24'd0, data}, 0);
        rst_n = 1'b1;
        wait_cycles(12 * CPB);
        chk("no_strobe_5a", sb_q.size(), 0);
        chk("after_abort_data", {24'd0, data}, 0);
        send_frame(8'h81, 1'b1, 1'b1);
        drain("drain_81");
        chk("hold_81", {24'd0, data}, 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
